// File: rtl/tick_timer.sv
// -----------------------------------------------------------------------------
// tick_timer
//
// Programmable tick generator. Emits a one-clock `tick` pulse every P clock
// cycles, where P is loaded at run time. Supports periodic and one-shot modes,
// start/stop control, and a sticky completion flag. With P fixed and `start`
// held high it behaves as a plain fixed-period divider.
//
// Parameters
//   W              width of the period register and the counter (W >= 2)
//   DEFAULT_PERIOD active period after reset (1 <= DEFAULT_PERIOD < 2**W)
//
// Ports
//   clk        in   system clock, rising edge
//   rstn       in   synchronous active-low reset
//   start      in   single-cycle (re)start request; a retrigger while running
//   stop       in   single-cycle halt request; wins over start
//   oneshot    in   mode sampled when a start is accepted (1 = one-shot)
//   period_we  in   write strobe for period_in
//   period_in  in   new period in clock cycles; 0 is stored as 1
//   tick       out  one-cycle pulse on the last cycle of each period
//   busy       out  high while running
//   done       out  sticky; set by one-shot completion, cleared by start
//   count      out  current counter value
// -----------------------------------------------------------------------------
module tick_timer #(
  parameter int W              = 24,
  parameter int DEFAULT_PERIOD = 1200000
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         start,
  input  logic         stop,
  input  logic         oneshot,
  input  logic         period_we,
  input  logic [W-1:0] period_in,
  output logic         tick,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] count
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [W-1:0] ONE       = W'(1);
  localparam logic [W-1:0] DEFAULT_P = W'(DEFAULT_PERIOD);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t       state_q,    state_d;
  logic [W-1:0] cnt_q,      cnt_d;
  logic [W-1:0] active_p_q, active_p_d;
  logic [W-1:0] pend_p_q,   pend_p_d;
  logic         pend_v_q,   pend_v_d;
  logic         mode_q,     mode_d;
  logic         done_q,     done_d;

  // Helper terms
  logic [W-1:0] period_fix;  // period_in with 0 mapped to 1
  logic         at_end;      // last cycle of the running period
  logic         apply_pend;  // this cycle ends the current period early or on time

  assign period_fix = (period_in == '0) ? ONE : period_in;
  assign at_end     = (state_q == RUN) && (cnt_q == active_p_q - ONE);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is assigned with non-blocking (<=) so every register
  // samples the values that existed before the edge, independent of statement
  // order.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      active_p_q <= DEFAULT_P;
      pend_v_q   <= 1'b0;
      mode_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      active_p_q <= active_p_d;
      pend_v_q   <= pend_v_d;
      mode_q     <= mode_d;
      done_q     <= done_d;
    end
  end

  // NOTE: the pending period is pure data qualified by pend_v_q, so it carries
  // no reset; its content is never used while the valid flag is low.
  always_ff @(posedge clk) begin
    pend_p_q <= pend_p_d;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    active_p_d = active_p_q;
    pend_p_d   = pend_p_q;
    pend_v_d   = pend_v_q;
    mode_d     = mode_q;
    done_d     = done_q;
    apply_pend = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // Nothing is in progress, so a new period takes effect immediately
        // and a start in the very next cycle already uses it.
        if (period_we) begin
          active_p_d = period_fix;
        end
        if (start && !stop) begin
          state_d = RUN;
          mode_d  = oneshot;
          done_d  = 1'b0;
        end
      end

      RUN: begin
        if (stop) begin
          state_d    = IDLE;
          cnt_d      = '0;
          apply_pend = 1'b1;
        end else if (start) begin
          // Retrigger: restart the period, re-sample the mode.
          cnt_d      = '0;
          mode_d     = oneshot;
          done_d     = 1'b0;
          apply_pend = 1'b1;
        end else if (at_end) begin
          cnt_d      = '0;
          apply_pend = 1'b1;
          if (mode_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + ONE;
        end

        // A period boundary (wrap, retrigger or exit) commits any pending
        // period written before this cycle.
        if (apply_pend) begin
          if (pend_v_q) begin
            active_p_d = pend_p_q;
          end
          pend_v_d = 1'b0;
        end

        // A write in this cycle never touches the period in progress. If we
        // stay in RUN it waits for the next boundary; if we are leaving RUN it
        // lands directly, as it would in IDLE, being the most recent write.
        if (period_we) begin
          if (state_d == IDLE) begin
            active_p_d = period_fix;
            pend_v_d   = 1'b0;
          end else begin
            pend_p_d = period_fix;
            pend_v_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs (combinational from registers only)
  // ---------------------------------------------------------------------------
  always_comb begin
    tick  = at_end;
    busy  = (state_q == RUN);
    done  = done_q;
    count = cnt_q;
  end

endmodule

// File: tb/tb_tick_timer.sv
module tb_tick_timer;

  localparam int W  = 24;
  localparam int DP = 6;  // small reset period so it can be observed

  logic         clk = 1'b0;
  logic         rstn;
  logic         start;
  logic         stop;
  logic         oneshot;
  logic         period_we;
  logic [W-1:0] period_in;
  logic         tick;
  logic         busy;
  logic         done;
  logic [W-1:0] count;

  tick_timer #(.W(W), .DEFAULT_PERIOD(DP)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .stop      (stop),
    .oneshot   (oneshot),
    .period_we (period_we),
    .period_in (period_in),
    .tick      (tick),
    .busy      (busy),
    .done      (done),
    .count     (count)
  );

  always #5 clk = ~clk;

  // One record per cycle: inputs driven during that cycle, and the outputs
  // expected in that same cycle (before the closing edge).
  typedef struct {
    logic         rstn;
    logic         start;
    logic         stop;
    logic         oneshot;
    logic         we;
    logic [W-1:0] pin;
    logic         e_tick;
    logic         e_busy;
    logic         e_done;
    logic [W-1:0] e_count;
  } vec_t;

  vec_t vecs[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic add(input logic r, input logic s, input logic p, input logic os,
                     input logic we, input int pin,
                     input logic et, input logic eb, input logic ed, input int ec);
    vec_t v;
    v.rstn = r; v.start = s; v.stop = p; v.oneshot = os; v.we = we; v.pin = W'(pin);
    v.e_tick = et; v.e_busy = eb; v.e_done = ed; v.e_count = W'(ec);
    vecs.push_back(v);
  endtask

  // Idle cycle with optional inputs; outputs expected all zero except done.
  task automatic add_idle(input logic s, input logic p, input logic os,
                          input logic we, input int pin, input logic ed);
    add(1'b1, s, p, os, we, pin, 1'b0, 1'b0, ed, 0);
  endtask

  // n quiet RUN cycles starting at counter c0 with period per.
  task automatic add_run(input int n, input int c0, input int per);
    int c;
    c = c0;
    for (int i = 0; i < n; i++) begin
      add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, (c == per - 1), 1'b1, 1'b0, c);
      c = (c == per - 1) ? 0 : c + 1;
    end
  endtask

  // Single RUN cycle with inputs.
  task automatic add_run1(input logic s, input logic p, input logic os,
                          input logic we, input int pin, input logic et, input int ec);
    add(1'b1, s, p, os, we, pin, et, 1'b1, 1'b0, ec);
  endtask

  initial begin
    int n;

    // --- reset, default period (6) observed ---
    add(1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add_idle(1, 0, 0, 0, 0, 0);
    add_run(6, 0, 6);                       // tick on count 5
    add_run1(0, 1, 0, 0, 0, 0, 0);          // stop

    // --- periodic P=5 written in IDLE: ticks at 4, 9, 14 ---
    add_idle(0, 0, 0, 1, 5, 0);
    add_idle(1, 0, 0, 0, 0, 0);
    add_run(15, 0, 5);
    add_run1(0, 1, 0, 0, 0, 0, 0);

    // --- one-shot P=3 ---
    add_idle(0, 0, 0, 1, 3, 0);
    add_idle(1, 0, 1, 0, 0, 0);
    add_run(3, 0, 3);                       // tick at count 2
    add_idle(0, 0, 0, 0, 0, 1);             // done set, busy low
    add_idle(0, 0, 0, 0, 0, 1);             // done holds
    add_idle(1, 0, 0, 0, 0, 1);             // start accepted here
    add_run1(0, 0, 0, 0, 0, 0, 0);          // done cleared
    add_run1(0, 1, 0, 0, 0, 0, 1);

    // --- periodic P=4, write 7 mid-period, then 2 on a wrap cycle ---
    add_idle(0, 0, 0, 1, 4, 0);
    add_idle(1, 0, 0, 0, 0, 0);
    add_run(5, 0, 4);                       // tick at count 3, back to 0
    add_run1(0, 0, 0, 1, 7, 0, 1);          // pending 7
    add_run(2, 2, 4);                       // tick still 4 after previous
    add_run(6, 0, 7);
    add_run1(0, 0, 0, 1, 2, 1, 6);          // wrap with write of 2
    add_run(7, 0, 7);                       // still 7
    add_run(2, 0, 2);                       // now 2
    add_run1(0, 1, 0, 0, 0, 0, 0);

    // --- period 0 -> 1, tick every RUN cycle; stop keeps its tick ---
    add_idle(0, 0, 0, 1, 0, 0);
    add_idle(1, 0, 0, 0, 0, 0);
    add_run(2, 0, 1);
    add_run1(0, 1, 0, 0, 0, 1, 0);
    add_idle(0, 0, 0, 1, 5, 0);             // tick gone after stop

    // --- start+stop together, then retrigger at count 2 ---
    add_idle(1, 0, 0, 0, 0, 0);
    add_run(1, 0, 5);
    add_run1(1, 1, 0, 0, 0, 0, 1);          // stop wins
    add_idle(1, 0, 0, 0, 0, 0);
    add_run(2, 0, 5);
    add_run1(1, 0, 0, 0, 0, 0, 2);          // retrigger
    add_run(5, 0, 5);                       // tick 4 cycles after restart
    add_run(4, 0, 5);
    add_run1(1, 0, 0, 0, 0, 1, 4);          // retrigger on wrap keeps tick
    add_run1(0, 0, 0, 1, 3, 0, 0);          // pending 3
    add_run1(1, 0, 0, 0, 0, 0, 1);          // retrigger applies 3 now
    add_run(3, 0, 3);
    add_run1(0, 1, 0, 0, 0, 0, 0);

    // --- reset mid-count discards pending write and restores default ---
    add_idle(0, 0, 0, 1, 5, 0);
    add_idle(1, 0, 0, 0, 0, 0);
    add_run(1, 0, 5);
    add_run1(0, 0, 0, 1, 9, 0, 1);          // pending 9
    add_run(1, 2, 5);
    add(1'b0, 0, 0, 0, 0, 0, 0, 1, 0, 3);   // reset at count 3
    add_idle(1, 0, 0, 0, 0, 0);             // all outputs 0
    add_run(12, 0, 6);                      // default 6, twice
    add_run1(0, 1, 0, 0, 0, 0, 0);
    add_idle(0, 0, 0, 0, 0, 0);

    // Apply the table.
    rstn = 1'b0; start = 1'b0; stop = 1'b0; oneshot = 1'b0;
    period_we = 1'b0; period_in = '0;
    repeat (2) @(posedge clk);
    foreach (vecs[i]) begin
      @(negedge clk);
      rstn      = vecs[i].rstn;
      start     = vecs[i].start;
      stop      = vecs[i].stop;
      oneshot   = vecs[i].oneshot;
      period_we = vecs[i].we;
      period_in = vecs[i].pin;
      check($sformatf("vec%0d", i),
            {5'd0, tick, busy, done, count},
            {5'd0, vecs[i].e_tick, vecs[i].e_busy, vecs[i].e_done, vecs[i].e_count});
    end

    // Hand-written: write P=8 in IDLE, one-shot start next cycle, bounded wait
    // for the tick, then completion status.
    @(negedge clk);
    rstn = 1'b1; start = 1'b0; stop = 1'b0; period_we = 1'b1; period_in = W'(8);
    @(negedge clk);
    period_we = 1'b0; start = 1'b1; oneshot = 1'b1;
    @(negedge clk);
    start = 1'b0; oneshot = 1'b0;
    check("os8_start_busy", {31'd0, busy}, 32'd1);
    n = 0;
    while (tick !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("os8_tick_latency", n, 7);
    @(negedge clk);
    check("os8_status", {29'd0, tick, busy, done}, {29'd0, 1'b0, 1'b0, 1'b1});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
